hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard and stall controller for the five-stage ARM pipeline. It drives the PC enable, the IF/ID enable and flush, the CU-MUX select (bubble insertion), and the enables of the ID/EX, EX/MEM and MEM/WB registers. It also produces the ID-stage operand forwarding selects. It sits beside the control unit in ID and consumes destination and control bits from the downstream pipeline registers; a small FSM freezes the whole pipeline while data memory is not ready.

## Interface
Parameters:
- WAIT_LIMIT, 15: maximum consecutive memory-wait frozen cycles before HALT; legal range 1..255.

Ports (one clock `clk`; `reset` is synchronous, active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_rn, id_rm  in  4  ID-stage source register numbers
- id_use_rn, id_use_rm  in  1  ID instruction actually reads Rn / Rm
- id_branch_taken  in  1  branch in ID resolved taken
- ex_rd  in  4  destination register in EX
- ex_reg_write, ex_mem_to_reg  in  1  EX write enable; EX holds a load
- mem_rd  in  4  destination register in MEM
- mem_reg_write  in  1  MEM write enable
- wb_rd  in  4  destination register in WB
- wb_reg_write  in  1  WB write enable
- mem_access  in  1  MEM stage performs a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_enable  out  1  PC load enable
- if_id_enable  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP at the next edge
- cu_mux_select  out  1  1 = CU-MUX outputs all-zero (bubble)
- pipe_enable  out  1  enable for ID/EX, EX/MEM, MEM/WB
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 EX, 10 MEM, 11 WB
- mem_timeout  out  1  sticky timeout flag
- state  out  2  FSM state (debug)

## Operation
- FSM states: RUN=00, MEM_WAIT=01, HALT=10. Reset state is RUN.
- Outputs are Mealy: combinational from the registered state plus inputs.
- While reset is high:
  - pc_enable=1, if_id_enable=1, pipe_enable=1
  - if_id_flush=0, cu_mux_select=0
  - fwd_a=fwd_b=00, mem_timeout=0
  - wait counter and perf counters cleared
- Event priority, highest first: HALT > memory freeze > load-use stall > branch flush.
- Memory freeze applies when mem_access=1 and mem_ready=0, in RUN or MEM_WAIT:
  - pc_enable, if_id_enable and pipe_enable all 0; cu_mux_select=0; if_id_flush=0.
  - Next state is MEM_WAIT.
  - wait_cnt increments (8-bit) on each frozen cycle.
- In MEM_WAIT with mem_ready=1: all enables are 1 that cycle, next state is RUN, and wait_cnt clears.
- Timeout: when a frozen cycle is the WAIT_LIMIT-th consecutive frozen cycle, the next state is HALT.
- HALT:
  - Every enable stays 0 and mem_timeout=1.
  - Only reset exits HALT.
- Load-use stall, in RUN with no freeze:
  - Condition: ex_mem_to_reg=1, ex_reg_write=1, and ex_rd matches a used ID source (id_rn with id_use_rn, or id_rm with id_use_rm).
  - Response: pc_enable=0, if_id_enable=0, cu_mux_select=1, pipe_enable=1.
  - A branch taken in the same cycle is ignored; the branch is re-evaluated next cycle.
- Branch flush, in RUN with no freeze or stall: id_branch_taken=1 gives if_id_flush=1 and all enables 1.
- Forwarding, evaluated per operand:
  - Select EX (01) if ex_reg_write=1, ex_mem_to_reg=0 and ex_rd matches.
  - Otherwise MEM (10) if mem_reg_write=1 and mem_rd matches.
  - Otherwise WB (11) if wb_reg_write=1 and wb_rd matches.
  - Otherwise 00.
  - Register 15 and operands not in use always give 00.
  - fwd_a and fwd_b are valid in every state.

## Timing
- Stall, flush and freeze take effect in the same cycle the inputs present them: zero latency, gating the next edge.
- A load-use stall lasts exactly 1 cycle. The bubble moves the load to MEM, so the condition self-clears.
- A freeze that starts in the same cycle as a load-use hazard gives a freeze only. The stall is evaluated after release.
- State and counters update on the rising edge of clk. A reset asserted mid-wait returns to RUN at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_count[15:0] and flush_count[15:0].
  - stall_count increments on each load-use bubble cycle; flush_count increments on each if_id_flush cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - FSM state encoding
  - fwd select encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB
  - register number constant REG_PC=15
- One natural sub-module: hazard_fwd_select, a combinational per-operand forwarding priority encoder instantiated twice, for fwd_a and fwd_b.

## Test plan
- Load-use stall: ex_mem_to_reg=1, ex_reg_write=1, ex_rd=3, id_rn=3, id_use_rn=1 -> one cycle of pc_enable=0, if_id_enable=0, cu_mux_select=1; next cycle (EX now bubble) all enables 1.
- Forwarding priority: id_rm=5, with EX, MEM and WB all writing r5 (EX not a load) -> fwd_b=01. Drop ex_reg_write -> 10. Drop mem_reg_write -> 11. Set id_rm=15 -> 00.
- Branch flush: id_branch_taken=1, no hazard -> if_id_flush=1, pc_enable=1. With a concurrent load-use hazard -> if_id_flush=0, cu_mux_select=1.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, state=01 after the first, release on cycle 4, state=00.
- Timeout: WAIT_LIMIT=4, mem_ready held 0 -> frozen cycles 0–3; from cycle 4 state=10 and mem_timeout=1. Raising mem_ready changes nothing; reset returns to RUN with mem_timeout=0.
- Perf counters (macro on): 3 stalls and 2 flushes -> stall_count=3, flush_count=2. Preload near saturation with 70000 stall events -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forwarding selects and the PC register number.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } hcu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_fwd_select.sv
// Per-operand forwarding priority encoder: EX (non-load) > MEM > WB > regfile.
// Purely combinational; r15 and unused operands always read the regfile.
module hazard_fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_use,
  input  logic [3:0] i_ex_rd,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_to_reg,
  input  logic [3:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [3:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_use && (i_src != REG_PC)) begin
      // A load in EX has no data yet; the load-use stall covers that case.
      if (i_ex_reg_write && !i_ex_mem_to_reg && (i_ex_rd == i_src))
        o_fwd = FWD_EX;
      else if (i_mem_reg_write && (i_mem_rd == i_src))
        o_fwd = FWD_MEM;
      else if (i_wb_reg_write && (i_wb_rd == i_src))
        o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/freeze controller with ID-stage forwarding selects.
// Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_rn,
  input  logic [3:0] id_rm,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic       id_branch_taken,
  input  logic [3:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_to_reg,
  input  logic [3:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [3:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       if_id_flush,
  output logic       cu_mux_select,
  output logic       pipe_enable,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  hcu_state_e r_state;
  hcu_state_e w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       w_freeze;
  logic       w_last_wait;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_freeze    = mem_access && !mem_ready;
  assign w_last_wait = (({1'b0, r_wait_cnt} + 9'd1) == 9'(WAIT_LIMIT));
  assign w_load_use  = ex_mem_to_reg && ex_reg_write &&
                       ((id_use_rn && (id_rn == ex_rd)) ||
                        (id_use_rm && (id_rm == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    pc_enable      = 1'b1;
    if_id_enable   = 1'b1;
    pipe_enable    = 1'b1;
    if_id_flush    = 1'b0;
    cu_mux_select  = 1'b0;
    mem_timeout    = 1'b0;
    w_next_state   = ST_RUN;
    w_wait_cnt_nxt = 8'd0;
    if (!reset) begin
      case (r_state)
        ST_HALT: begin
          pc_enable      = 1'b0;
          if_id_enable   = 1'b0;
          pipe_enable    = 1'b0;
          mem_timeout    = 1'b1;
          w_next_state   = ST_HALT;
          w_wait_cnt_nxt = r_wait_cnt;
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (w_freeze) begin
            pc_enable      = 1'b0;
            if_id_enable   = 1'b0;
            pipe_enable    = 1'b0;
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            w_next_state   = w_last_wait ? ST_HALT : ST_MEM_WAIT;
          end else if (r_state == ST_RUN && w_load_use) begin
            // Bubble into ID/EX; any same-cycle branch is re-seen next cycle.
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            cu_mux_select = 1'b1;
          end else if (r_state == ST_RUN && id_branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  hazard_fwd_select u_fwd_a (
    .i_src          (id_rn),
    .i_use          (id_use_rn),
    .i_ex_rd        (ex_rd),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_mem_to_reg(ex_mem_to_reg),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (w_fwd_a)
  );

  hazard_fwd_select u_fwd_b (
    .i_src          (id_rm),
    .i_use          (id_use_rm),
    .i_ex_rd        (ex_rd),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_mem_to_reg(ex_mem_to_reg),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (w_fwd_b)
  );

  assign fwd_a = reset ? FWD_RF : w_fwd_a;
  assign fwd_b = reset ? FWD_RF : w_fwd_b;
  assign state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (cu_mux_select && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
      if (if_id_flush && (r_flush_count != 16'hFFFF))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed table-driven bench for hazard_control_unit (WAIT_LIMIT=4),
// plus hand sequences for stall, memory wait, timeout and perf counters.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic       id_use_rn, id_use_rm, id_branch_taken;
  logic       ex_reg_write, ex_mem_to_reg, mem_reg_write, wb_reg_write;
  logic       mem_access, mem_ready;
  logic       pc_enable, if_id_enable, if_id_flush, cu_mux_select, pipe_enable;
  logic [1:0] fwd_a, fwd_b, state;
  logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .cu_mux_select(cu_mux_select), .pipe_enable(pipe_enable),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // ctl packs {pc_enable, if_id_enable, if_id_flush, cu_mux_select, pipe_enable}
  typedef struct {
    logic [3:0] rn, rm;
    logic       urn, urm, br;
    logic [3:0] exd;
    logic       exw, exl;
    logic [3:0] mmd;
    logic       mmw;
    logic [3:0] wbd;
    logic       wbw;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tv[14];

  function automatic logic [4:0] ctl_now();
    return {pc_enable, if_id_enable, if_id_flush, cu_mux_select, pipe_enable};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0; id_branch_taken = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    mem_access = 0; mem_ready = 1;
  endtask

  task automatic set_load_use();
    id_rn = 3; id_use_rn = 1; ex_rd = 3; ex_reg_write = 1; ex_mem_to_reg = 1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  initial begin
    //          rn rm urn urm br exd exw exl mmd mmw wbd wbw ctl       fa fb
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0, 0};
    tv[1]  = '{3, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0};
    tv[2]  = '{0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0};
    tv[3]  = '{3, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 5'b11001, 0, 0};
    tv[4]  = '{3, 0, 1, 0, 0, 3, 0, 1, 0, 0, 0, 0, 5'b11001, 0, 0};
    tv[5]  = '{0, 5, 0, 1, 0, 5, 1, 0, 5, 1, 5, 1, 5'b11001, 0, 1};
    tv[6]  = '{0, 5, 0, 1, 0, 5, 0, 0, 5, 1, 5, 1, 5'b11001, 0, 2};
    tv[7]  = '{0, 5, 0, 1, 0, 5, 0, 0, 5, 0, 5, 1, 5'b11001, 0, 3};
    tv[8]  = '{0, 15, 0, 1, 0, 15, 1, 0, 15, 1, 15, 1, 5'b11001, 0, 0};
    tv[9]  = '{0, 5, 0, 0, 0, 5, 1, 0, 5, 1, 5, 1, 5'b11001, 0, 0};
    tv[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 0, 0};
    tv[11] = '{3, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0};
    tv[12] = '{2, 0, 1, 0, 0, 2, 1, 1, 2, 1, 0, 0, 5'b00011, 2, 0};
    tv[13] = '{4, 6, 1, 1, 0, 6, 1, 0, 0, 0, 4, 1, 5'b11001, 3, 1};

    clr();
    reset = 1;
    set_load_use();
    wb_rd = 3; wb_reg_write = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ctl", 32'(ctl_now()), 32'(5'b11001));
    chk("reset fwd_a", 32'(fwd_a), 0);
    chk("reset timeout", 32'(mem_timeout), 0);
    chk("reset state", 32'(state), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset stall_count", 32'(stall_count), 0);
    chk("reset flush_count", 32'(flush_count), 0);
`endif
    @(negedge clk); reset = 0; clr();

    // Table vectors: all in RUN, no memory access.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_rn = tv[i].rn; id_rm = tv[i].rm; id_use_rn = tv[i].urn; id_use_rm = tv[i].urm;
      id_branch_taken = tv[i].br;
      ex_rd = tv[i].exd; ex_reg_write = tv[i].exw; ex_mem_to_reg = tv[i].exl;
      mem_rd = tv[i].mmd; mem_reg_write = tv[i].mmw;
      wb_rd = tv[i].wbd; wb_reg_write = tv[i].wbw;
      #1;
      chk($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(tv[i].ctl));
      chk($sformatf("vec%0d fwd_a", i), 32'(fwd_a), 32'(tv[i].fa));
      chk($sformatf("vec%0d fwd_b", i), 32'(fwd_b), 32'(tv[i].fb));
      chk($sformatf("vec%0d state", i), 32'(state), 0);
    end

    do_reset();
`ifdef HAZARD_PERF_CNT_EN
    chk("perf clear stall", 32'(stall_count), 0);
    chk("perf clear flush", 32'(flush_count), 0);
`endif

    // Load-use stall lasts one cycle; the load then sits in MEM.
    @(negedge clk); clr(); set_load_use(); #1;
    chk("lu stall ctl", 32'(ctl_now()), 32'(5'b00011));
    @(negedge clk);
    ex_reg_write = 0; ex_mem_to_reg = 0; ex_rd = 0; mem_rd = 3; mem_reg_write = 1; #1;
    chk("lu release ctl", 32'(ctl_now()), 32'(5'b11001));
    chk("lu release fwd_a", 32'(fwd_a), 2);

    // Memory wait of 3 cycles; first freeze cycle also carries a load-use hazard.
    @(negedge clk); clr(); set_load_use(); mem_access = 1; mem_ready = 0; #1;
    chk("mw f1 ctl", 32'(ctl_now()), 32'(5'b00000));
    chk("mw f1 state", 32'(state), 0);
    @(negedge clk); clr(); mem_access = 1; mem_ready = 0; #1;
    chk("mw f2 ctl", 32'(ctl_now()), 32'(5'b00000));
    chk("mw f2 state", 32'(state), 1);
    @(negedge clk); #1;
    chk("mw f3 ctl", 32'(ctl_now()), 32'(5'b00000));
    chk("mw f3 state", 32'(state), 1);
    @(negedge clk); mem_ready = 1; #1;
    chk("mw release ctl", 32'(ctl_now()), 32'(5'b11001));
    chk("mw release state", 32'(state), 1);
    @(negedge clk); clr(); #1;
    chk("mw after state", 32'(state), 0);

    // Reset during a wait returns to RUN.
    @(negedge clk); mem_access = 1; mem_ready = 0;
    @(negedge clk); #1;
    chk("midwait state", 32'(state), 1);
    @(negedge clk); reset = 1; #1;
    chk("midwait reset ctl", 32'(ctl_now()), 32'(5'b11001));
    @(negedge clk); reset = 0; clr(); #1;
    chk("midwait reset state", 32'(state), 0);

    // Timeout at WAIT_LIMIT=4 frozen cycles.
    @(negedge clk); mem_access = 1; mem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("to frozen%0d ctl", c), 32'(ctl_now()), 32'(5'b00000));
      chk($sformatf("to frozen%0d state", c), 32'(state), (c == 0) ? 0 : 1);
      @(negedge clk);
    end
    #1;
    chk("halt state", 32'(state), 2);
    chk("halt timeout", 32'(mem_timeout), 1);
    chk("halt ctl", 32'(ctl_now()), 32'(5'b00000));
    mem_ready = 1; id_rn = 4; id_use_rn = 1; wb_rd = 4; wb_reg_write = 1; id_branch_taken = 1;
    @(negedge clk); #1;
    chk("halt hold state", 32'(state), 2);
    chk("halt hold ctl", 32'(ctl_now()), 32'(5'b00000));
    chk("halt fwd_a", 32'(fwd_a), 3);
    do_reset(); clr(); #1;
    chk("post-halt state", 32'(state), 0);
    chk("post-halt timeout", 32'(mem_timeout), 0);

`ifdef HAZARD_PERF_CNT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); clr(); set_load_use();
      @(negedge clk); clr();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); clr(); id_branch_taken = 1;
    end
    @(negedge clk); clr(); #1;
    chk("perf stall_count", 32'(stall_count), 3);
    chk("perf flush_count", 32'(flush_count), 2);
    @(negedge clk); set_load_use();
    repeat (70000) @(negedge clk);
    clr(); #1;
    chk("perf stall sat", 32'(stall_count), 32'h0000FFFF);
    chk("perf flush hold", 32'(flush_count), 2);
    do_reset(); #1;
    chk("perf reset stall", 32'(stall_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
